// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int MAX_FRAME = 256;
    localparam int CNT_W     = 9;

endpackage

// File: rtl/mem_loader_if.sv
// Host byte stream (valid/ready) plus the memory write port driven by the loader.
interface mem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;

    // master: host byte source that also observes the memory write port
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );

endinterface

// File: rtl/mem_loader.sv
// Boot loader: parses ADDR/COUNT/payload/CHK frames, writes payload to memory,
// and releases the CPU only after a frame whose checksum sums to zero.
//
// state   | meaning
// S_IDLE  | just out of reset, arms on the next edge
// S_ADDR  | waiting for the start-address byte
// S_COUNT | waiting for the payload length byte (0 means 256)
// S_DATA  | streaming payload bytes into memory
// S_CHECK | waiting for the checksum byte
// S_DONE  | frame good, CPU released
// S_ERR   | checksum failed, CPU held
module mem_loader
    import mem_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    mem_loader_if.slave  bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         ptr;
    logic [7:0]         sum;
    logic [7:0]         sum_nx;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    assign sum_nx = sum + bus.in_data;
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.in_ready = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_hold     = 1'b1;
        case (state)
            S_IDLE:  state_nx = S_ADDR;
            S_ADDR: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = S_COUNT;
            end
            S_COUNT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = S_DATA;
            end
            S_DATA: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && cnt == CNT_W'(1)) state_nx = S_CHECK;
            end
            S_CHECK: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = (sum_nx == 8'h00) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = S_ADDR;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nx = S_ADDR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Write port is registered: a payload byte accepted at edge k is presented during cycle k+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= 8'h00;
            sum          <= 8'h00;
            cnt          <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= 8'h00;
            bus.mem_data <= 8'h00;
        end else begin
            bus.mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_ADDR: begin
                        ptr <= bus.in_data;
                        sum <= bus.in_data;
                    end
                    S_COUNT: begin
                        cnt <= (bus.in_data == 8'h00) ? CNT_W'(MAX_FRAME) : {1'b0, bus.in_data};
                        sum <= sum_nx;
                    end
                    S_DATA: begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= ptr;
                        bus.mem_data <= bus.in_data;
                        ptr          <= ptr + 8'd1;
                        cnt          <= cnt - CNT_W'(1);
                        sum          <= sum_nx;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
